instr_fetch_unit: RTL and testbench

Fetch stage of the RV32 core. Owns the program counter, drives the word address into the combinational instruction memory, and buffers fetched words in a small queue. The queue presents `{pc, instr, fault}` to the decode stage over a valid/ready handshake. Branch and jump resolution redirects the PC and flushes the queue.

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: registered PC drives imem, fetched words queue toward decode; head valid one cycle after fetch.
// Backpressure: full queue with id_ready=0 stalls fetch and holds the PC; redirect flushes the queue and restarts fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 32,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_fault
);

  localparam int          PW        = $clog2(DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic {S_FETCH, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     q_pc_q    [DEPTH];
  logic [31:0]     q_pc_d    [DEPTH];
  logic [31:0]     q_instr_q [DEPTH];
  logic [31:0]     q_instr_d [DEPTH];
  logic            q_fault_q [DEPTH];
  logic            q_fault_d [DEPTH];

  logic fetch_en;
  logic fault;
  logic pop;
  logic push;

  assign fault = (pc_q[1:0] != 2'b00) || (pc_q > LAST_ADDR);
  assign pop   = (count_q != '0) && id_ready && !redirect_valid;
  assign push  = fetch_en && !redirect_valid && ((count_q != CW'(DEPTH)) || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = S_FETCH;
    end else if (push && fault) begin
      state_d = S_HALT;
    end
  end

  always_comb begin
    fetch_en = (state_q == S_FETCH);
  end

  always_comb begin
    pc_d      = pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    q_pc_d    = q_pc_q;
    q_instr_d = q_instr_q;
    q_fault_d = q_fault_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        q_pc_d[wr_ptr_q]    = pc_q;
        q_instr_d[wr_ptr_q] = fault ? NOP : imem_rdata;
        q_fault_d[wr_ptr_q] = fault;
        wr_ptr_d            = wr_ptr_q + PW'(1);
        // A faulting fetch parks the PC on the bad address until redirected.
        if (!fault) begin
          pc_d = pc_q + 32'd4;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
        q_fault_q[i] <= 1'b0;
      end
    end else begin
      pc_q      <= pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      q_pc_q    <= q_pc_d;
      q_instr_q <= q_instr_d;
      q_fault_q <= q_fault_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = (count_q != '0);
  assign id_pc       = id_valid ? q_pc_q[rd_ptr_q] : 32'd0;
  assign id_pc_plus4 = id_valid ? (q_pc_q[rd_ptr_q] + 32'd4) : 32'd0;
  assign id_instr    = id_valid ? q_instr_q[rd_ptr_q] : 32'd0;
  assign id_fault    = id_valid ? q_fault_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async-reset sequence, then random traffic vs a queue model.
module tb_instr_fetch_unit;

  localparam int          DEPTH      = 2;
  localparam int          IMEM_BYTES = 32;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_fault;

  logic [31:0] mem [8];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[4:2]];

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(IMEM_BYTES),
    .DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .id_fault      (id_fault)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ef;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rv, logic [31:0] rpc, logic rdy,
                              logic ev, logic [31:0] epc, logic [31:0] einstr,
                              logic ef, logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.ef = ef; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic ev, input logic [31:0] epc,
                       input logic [31:0] einstr, input logic ef, input logic [31:0] eaddr);
    logic [31:0] ep4;
    ep4 = ev ? (epc + 32'd4) : 32'd0;
    n_vec++;
    if (id_valid !== ev || id_pc !== epc || id_instr !== einstr || id_fault !== ef ||
        id_pc_plus4 !== ep4 || imem_addr !== eaddr) begin
      n_err++;
      $display("FAIL %s: got v=%0b pc=%h instr=%h f=%0b p4=%h addr=%h, want v=%0b pc=%h instr=%h f=%0b p4=%h addr=%h",
               name, id_valid, id_pc, id_instr, id_fault, id_pc_plus4, imem_addr,
               ev, epc, einstr, ef, ep4, eaddr);
    end
  endtask

  // Reference model: fetch queue as a plain SV queue, PC and a halted flag.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    bit   do_pop;
    bit   do_push;
    bit   f;
    ent_t e;
    if (rv) begin
      mq.delete();
      m_pc   = rpc;
      m_halt = 1'b0;
      return;
    end
    do_pop  = (mq.size() > 0) && rdy;
    do_push = !m_halt && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      f       = (m_pc % 4 != 0) || (m_pc > IMEM_BYTES - 4);
      e.pc    = m_pc;
      e.instr = f ? NOP : mem[m_pc[4:2]];
      e.fault = f;
      mq.push_back(e);
      if (f) m_halt = 1'b1;
      else   m_pc   = m_pc + 32'd4;
    end
  endtask

  task automatic model_check(input string name);
    if (mq.size() > 0) check(name, 1'b1, mq[0].pc, mq[0].instr, mq[0].fault, m_pc);
    else               check(name, 1'b0, 32'h0, 32'h0, 1'b0, m_pc);
  endtask

  initial begin
    mem[0] = 32'hFFC4A303;
    mem[1] = 32'h0064A423;
    mem[2] = 32'h0062E233;
    for (int i = 3; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i);

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;

    // rst rv rpc rdy | valid pc instr fault addr
    vecs.push_back(mk(0, 0, 0,     1, 1, 32'h00, mem[0], 0, 32'h04));
    vecs.push_back(mk(0, 0, 0,     1, 1, 32'h04, mem[1], 0, 32'h08));
    vecs.push_back(mk(0, 0, 0,     1, 1, 32'h08, mem[2], 0, 32'h0C));
    vecs.push_back(mk(1, 0, 0,     0, 0, 32'h00, 32'h0,  0, 32'h00));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h00, mem[0], 0, 32'h04));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h00, mem[0], 0, 32'h08));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h00, mem[0], 0, 32'h08));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h00, mem[0], 0, 32'h08));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h00, mem[0], 0, 32'h08));
    vecs.push_back(mk(0, 0, 0,     1, 1, 32'h04, mem[1], 0, 32'h0C));
    vecs.push_back(mk(0, 0, 0,     1, 1, 32'h08, mem[2], 0, 32'h10));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h08, mem[2], 0, 32'h10));
    vecs.push_back(mk(0, 1, 32'h10, 0, 0, 32'h00, 32'h0,  0, 32'h10));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h10, mem[4], 0, 32'h14));
    vecs.push_back(mk(0, 1, 32'h1C, 1, 0, 32'h00, 32'h0,  0, 32'h1C));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h1C, mem[7], 0, 32'h20));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h1C, mem[7], 0, 32'h20));
    vecs.push_back(mk(0, 0, 0,     1, 1, 32'h20, NOP,    1, 32'h20));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h20, NOP,    1, 32'h20));
    vecs.push_back(mk(0, 0, 0,     1, 0, 32'h00, 32'h0,  0, 32'h20));
    vecs.push_back(mk(0, 0, 0,     1, 0, 32'h00, 32'h0,  0, 32'h20));
    vecs.push_back(mk(0, 1, 32'h00, 1, 0, 32'h00, 32'h0,  0, 32'h00));
    vecs.push_back(mk(0, 0, 0,     1, 1, 32'h00, mem[0], 0, 32'h04));
    vecs.push_back(mk(0, 1, 32'h06, 0, 0, 32'h00, 32'h0,  0, 32'h06));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h06, NOP,    1, 32'h06));
    vecs.push_back(mk(0, 0, 0,     0, 1, 32'h06, NOP,    1, 32'h06));
    vecs.push_back(mk(0, 0, 0,     1, 0, 32'h00, 32'h0,  0, 32'h06));

    repeat (2) @(negedge clk);
    check("reset_state", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      reset          = vecs[i].rst;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      id_ready       = vecs[i].rdy;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr, vecs[i].ef, vecs[i].eaddr);
    end

    // Async reset between edges with one entry queued.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_async_rst", 1'b1, 32'h0, mem[0], 1'b0, 32'h04);
    #1 reset = 1'b1;
    #1 check("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst;
      logic        r_rv;
      logic [31:0] r_pc;
      logic        r_rdy;
      model_check("random");
      r_rst = ($urandom_range(0, 99) == 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      r_pc  = 32'($urandom_range(0, 10)) * 32'd4;
      if ($urandom_range(0, 3) == 0) r_pc = r_pc + 32'($urandom_range(1, 3));
      r_rdy = ($urandom_range(0, 2) != 0);
      reset          = r_rst;
      redirect_valid = r_rv;
      redirect_pc    = r_pc;
      id_ready       = r_rdy;
      if (r_rst) model_reset();
      else       model_step(r_rv, r_pc, r_rdy);
      @(posedge clk);
      @(negedge clk);
    end
    model_check("random_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
